// File: rtl/alu_pkg.sv
// Shared types and default sizing for the serial add/subtract flag generator.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE-bit adder with carry-in and carry-out.
module slice_adder #(
  parameter int SLICE = alu_pkg::DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  // Widen by one bit so the carry falls out of the top of the sum.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  end

endmodule

// File: rtl/serial_flag_gen.sv
// Serial add/subtract: one SLICE-bit chunk per cycle, with zero/overflow/negative/carry flags.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result and flags hold the last operation
// RUN   | adding slice cnt each edge, carry rippling through a register
// DONE  | one-cycle done pulse; result and flags valid
module serial_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  state_t            state, next_state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic              carry;
  logic              nz_acc;
  logic              last;
  int                base;
  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout;

  // Select the operand slice addressed by the counter.
  always_comb begin
    base    = int'(cnt) * SLICE;
    slice_a = opa[base +: SLICE];
    slice_b = opb[base +: SLICE];
    last    = (cnt == LAST_CNT);
  end

  slice_adder #(.SLICE(SLICE)) u_slice_adder (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and status outputs.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, slice accumulation in RUN, flags on the last slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      nz_acc <= 1'b0;
      result <= '0;
      z      <= 1'b1;
      v      <= 1'b0;
      n      <= 1'b0;
      c      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here and feed the +1 as carry-in.
            opa    <= a;
            opb    <= b ^ {WIDTH{sub}};
            carry  <= sub;
            cnt    <= '0;
            nz_acc <= 1'b0;
          end
        end
        RUN: begin
          result[base +: SLICE] <= slice_sum;
          carry  <= slice_cout;
          nz_acc <= nz_acc | (|slice_sum);
          if (last) begin
            cnt <= '0;
            // The top slice is still on the adder output, so derive the flags from it directly.
            z <= ~(nz_acc | (|slice_sum));
            n <= slice_sum[SLICE-1];
            c <= slice_cout;
            v <= (opa[WIDTH-1] == opb[WIDTH-1]) && (slice_sum[SLICE-1] != opa[WIDTH-1]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
